iir_biquad_seq: RTL and testbench

IIR_BIQUAD_SEQ -- requirements
Module: iir_biquad_seq

---
 rtl/iir_biquad_seq.sv | 162 ++++++++++++++++
 tb/tb_iir_biquad_seq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/iir_biquad_seq.sv
// Sequential single-MAC direct-form-I biquad: one product per cycle over five coefficients.
// Optional macro IIR_ROUND_EN selects round-half-up scaling instead of floor truncation.
module iir_biquad_seq #(
  parameter int W    = 25,
  parameter int FRAC = 14
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic [W-1:0] x_in,
  input  logic         x_valid,
  output logic [2:0]   coef_sel,
  input  logic [W-1:0] coef,
  output logic [W-1:0] y_out,
  output logic         y_valid,
  output logic         busy,
  output logic         sat_flag
);

  localparam int PW = 2 * W;
  localparam int AW = 2 * W + 3;
  localparam int SW = AW + 1;

`ifdef IIR_ROUND_EN
  localparam logic signed [SW-1:0] HALF = {{(SW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
`endif

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t state, state_nxt;

  logic        [2:0]    idx;
  logic signed [W-1:0]  xl, x1, x2, y1, y2;
  logic signed [AW-1:0] acc;
  logic signed [W-1:0]  operand;
  logic signed [PW-1:0] coef_ext, op_ext, prod;
  logic signed [AW-1:0] prod_ext;
  logic signed [SW-1:0] scaled;
  logic        [W:0]    sat_res;
  logic signed [W-1:0]  y_new;
  logic                 y_sat;

  // Extra guard bit so the rounding constant can never wrap the accumulator.
  function automatic logic signed [SW-1:0] scale_acc(input logic signed [AW-1:0] a);
    logic signed [SW-1:0] t;
    t = {a[AW-1], a};
`ifdef IIR_ROUND_EN
    t = t + HALF;
`endif
    return t >>> FRAC;
  endfunction

  // Returns {overflow, clamped value}; in range when all bits above the sign agree.
  function automatic logic [W:0] saturate(input logic signed [SW-1:0] v);
    logic [SW-W:0] hi;
    hi = v[SW-1:W-1];
    if (hi == '0 || hi == '1)
      return {1'b0, v[W-1:0]};
    else if (v[SW-1])
      return {1'b1, 1'b1, {(W-1){1'b0}}};
    else
      return {1'b1, 1'b0, {(W-1){1'b1}}};
  endfunction

  always_comb begin
    operand = '0;
    case (idx)
      3'd0:    operand = y1;
      3'd1:    operand = y2;
      3'd2:    operand = xl;
      3'd3:    operand = x1;
      3'd4:    operand = x2;
      default: operand = '0;
    endcase
  end

  assign coef_ext = {{W{coef[W-1]}}, coef};
  assign op_ext   = {{W{operand[W-1]}}, operand};
  assign prod     = coef_ext * op_ext;
  assign prod_ext = {{(AW-PW){prod[PW-1]}}, prod};

  assign scaled  = scale_acc(acc);
  assign sat_res = saturate(scaled);
  assign y_new   = sat_res[W-1:0];
  assign y_sat   = sat_res[W];

  assign busy     = (state != IDLE);
  assign coef_sel = (state == MAC) ? idx : 3'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (x_valid) state_nxt = MAC;
        MAC:     if (idx == 3'd4) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx      <= '0;
      acc      <= '0;
      xl       <= '0;
      x1       <= '0;
      x2       <= '0;
      y1       <= '0;
      y2       <= '0;
      y_out    <= '0;
      y_valid  <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      y_valid <= 1'b0;
      if (clear) begin
        // y_out deliberately keeps the last published sample.
        idx      <= '0;
        acc      <= '0;
        xl       <= '0;
        x1       <= '0;
        x2       <= '0;
        y1       <= '0;
        y2       <= '0;
        sat_flag <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (x_valid) begin
              xl  <= x_in;
              acc <= '0;
              idx <= '0;
            end
          end
          MAC: begin
            acc <= acc + prod_ext;
            idx <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
          end
          DONE: begin
            y_out    <= y_new;
            y_valid  <= 1'b1;
            sat_flag <= sat_flag | y_sat;
            y2       <= y1;
            y1       <= y_new;
            x2       <= x1;
            x1       <= xl;
            idx      <= '0;
          end
          default: idx <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iir_biquad_seq.sv
// Randomized bench for iir_biquad_seq against a difference-equation reference model.
// Build with IIR_ROUND_EN defined to exercise the rounding mode.
module tb_iir_biquad_seq;

  localparam int W    = 25;
  localparam int FRAC = 14;
  localparam longint MAXV = (longint'(1) << (W-1)) - 1;
  localparam longint MINV = -(longint'(1) << (W-1));

  logic         clk = 1'b0;
  logic         reset, clear, x_valid;
  logic [W-1:0] x_in, coef, y_out;
  logic [2:0]   coef_sel;
  logic         y_valid, busy, sat_flag;

  longint cf[5];
  longint mx1, mx2, my1, my2;
  bit     msat;
  int     nvec = 0;
  int     nerr = 0;

  iir_biquad_seq #(.W(W), .FRAC(FRAC)) dut (
    .clk(clk), .reset(reset), .clear(clear), .x_in(x_in), .x_valid(x_valid),
    .coef_sel(coef_sel), .coef(coef), .y_out(y_out), .y_valid(y_valid),
    .busy(busy), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  always_comb coef = (coef_sel < 3'd5) ? W'(cf[coef_sel]) : '0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint sx(input logic [W-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint rnd_s(input int bits);
    return longint'($urandom_range(0, (1 << bits) - 1)) - (longint'(1) << (bits - 1));
  endfunction

  function automatic void model_clear();
    mx1 = 0; mx2 = 0; my1 = 0; my2 = 0; msat = 1'b0;
  endfunction

  function automatic longint model_step(input longint x);
    longint acc, v;
    acc = cf[0]*my1 + cf[1]*my2 + cf[2]*x + cf[3]*mx1 + cf[4]*mx2;
`ifdef IIR_ROUND_EN
    acc = acc + (longint'(1) << (FRAC - 1));
`endif
    v = acc >>> FRAC;
    if (v > MAXV) begin v = MAXV; msat = 1'b1; end
    else if (v < MINV) begin v = MINV; msat = 1'b1; end
    my2 = my1; my1 = v; mx2 = mx1; mx1 = x;
    return v;
  endfunction

  task automatic set_imp();
    cf[0] = 32113; cf[1] = -15737; cf[2] = 3; cf[3] = 7; cf[4] = 3;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; tick(); clear = 1'b0;
    model_clear();
  endtask

  // Accept one sample, wait for its result, compare latency, value and flag.
  task automatic do_sample(input longint x, input bit chk_sel);
    int n;
    longint e;
    x_in = W'(x); x_valid = 1'b1;
    tick();
    x_valid = 1'b0;
    chk("busy_rise", busy, 1);
    if (chk_sel) chk("coef_sel_0", coef_sel, 0);
    n = 0;
    while (!y_valid && n < 20) begin
      tick();
      n++;
      if (chk_sel && n <= 4) chk("coef_sel_seq", coef_sel, n);
      if (chk_sel && n == 5) chk("coef_sel_done", coef_sel, 0);
    end
    chk("latency", n, 6);
    chk("busy_fall", busy, 0);
    e = model_step(x);
    chk("y_out", sx(y_out), e);
    chk("sat_flag", sat_flag, msat);
  endtask

  initial begin
    int cnt;
    longint xs, e;
    reset = 1'b1; clear = 1'b0; x_valid = 1'b0; x_in = '0;
    set_imp();
    model_clear();
    repeat (3) tick();
    chk("rst_y_out", y_out, 0);
    chk("rst_y_valid", y_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sat", sat_flag, 0);
    chk("rst_coef_sel", coef_sel, 0);
    reset = 1'b0;
    tick();

    // Impulse response start.
    do_sample(16384, 1'b1);
    chk("imp_y0", sx(y_out), 3);
    do_sample(0, 1'b1);
`ifdef IIR_ROUND_EN
    chk("imp_y1", sx(y_out), 13);
`else
    chk("imp_y1", sx(y_out), 12);
`endif
    for (int i = 0; i < 6; i++) do_sample(0, 1'b0);

    // Random coefficients and samples.
    for (int r = 0; r < 4; r++) begin
      cf[0] = rnd_s(16); cf[1] = rnd_s(15);
      cf[2] = rnd_s(16); cf[3] = rnd_s(16); cf[4] = rnd_s(16);
      pulse_clear();
      for (int i = 0; i < 12; i++) do_sample(rnd_s(W - (i % 3) * 6), 1'b0);
    end

    // x_valid held through three calculations: only every 7th edge accepts.
    xs = rnd_s(20);
    x_in = W'(xs); x_valid = 1'b1;
    cnt = 0;
    for (int i = 0; i < 21; i++) begin
      tick();
      if (y_valid) begin
        cnt++;
        e = model_step(xs);
        chk("spam_y", sx(y_out), e);
      end
    end
    x_valid = 1'b0;
    chk("spam_count", cnt, 3);
    tick();
    chk("spam_idle", busy, 0);

    // clear together with x_valid drops the sample and wipes history.
    set_imp();
    do_sample(rnd_s(W), 1'b0);
    do_sample(rnd_s(W), 1'b0);
    x_in = W'(16384); x_valid = 1'b1; clear = 1'b1;
    tick();
    x_valid = 1'b0; clear = 1'b0;
    model_clear();
    chk("clr_busy", busy, 0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (y_valid || busy) cnt++;
    end
    chk("clr_no_calc", cnt, 0);
    do_sample(16384, 1'b0);
    chk("clr_imp_y0", sx(y_out), 3);
    do_sample(0, 1'b0);
`ifdef IIR_ROUND_EN
    chk("clr_imp_y1", sx(y_out), 13);
`else
    chk("clr_imp_y1", sx(y_out), 12);
`endif

    // Sustained full-scale input drives the output into positive saturation.
    pulse_clear();
    cnt = 0;
    for (int i = 0; i < 2000; i++) begin
      do_sample(longint'(24'hFFFFFF), 1'b0);
      if (y_out[W-1]) cnt++;
    end
    chk("sat_negatives", cnt, 0);
    chk("sat_y_max", y_out, 25'h0FFFFFF);
    chk("sat_flag_set", sat_flag, 1);
    pulse_clear();
    chk("sat_flag_clr", sat_flag, 0);
    chk("clr_y_hold", y_out, 25'h0FFFFFF);

    // Reset asserted at MAC index 2 aborts and zeroes everything at once.
    set_imp();
    pulse_clear();
    do_sample(16384, 1'b0);
    x_in = W'(20000); x_valid = 1'b1;
    tick();
    x_valid = 1'b0;
    tick(); tick();
    chk("mid_idx", coef_sel, 2);
    reset = 1'b1;
    #1;
    chk("mid_y_out", y_out, 0);
    chk("mid_y_valid", y_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_coef_sel", coef_sel, 0);
    chk("mid_sat", sat_flag, 0);
    tick(); tick();
    reset = 1'b0;
    model_clear();
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (y_valid) cnt++;
    end
    chk("mid_no_valid", cnt, 0);
    do_sample(16384, 1'b1);
    chk("post_rst_y0", sx(y_out), 3);
    do_sample(0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
